// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 capture path and the VGA frame-buffer reader.
//   cap_state_t : capture FSM states
//   FB_DEPTH    : frame-buffer depth in pixels (640x480)
//   FB_AW       : frame-buffer address width
//   GREY_W      : stored grey value width
//   grey_of()   : luma byte -> stored grey value
package ov7670_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SYNC      = 2'd1,
    ACTIVE    = 2'd2
  } cap_state_t;

  localparam int FB_DEPTH = 640 * 480;
  localparam int FB_AW    = 19;
  localparam int GREY_W   = 4;

  // Grey reduction keeps only the top bits of the luma byte.
  function automatic logic [GREY_W-1:0] grey_of(input logic [7:0] y);
    return y[7 -: GREY_W];
  endfunction

endpackage

// File: rtl/ov7670_capture.sv
// OV7670 DVP capture: samples VSYNC/HREF/D[7:0] (YUV422), keeps the luma byte
// of each pixel reduced to 4-bit grey, and writes it linearly (row-major) into
// the frame buffer read by the VGA block.
// Ports:
//   clk24       in   camera PCLK, all logic on the rising edge
//   rst         in   asynchronous active-high reset
//   cam_vsync   in   camera VSYNC
//   cam_href    in   camera HREF, high while line bytes are valid
//   cam_data    in   camera pixel byte
//   frame_we    out  one-cycle write strobe per pixel
//   frame_addr  out  frame-buffer write address
//   frame_pixel out  grey value (Y[7:4])
//   frame_done  out  one-cycle pulse when a frame has been written
//   line_err    out  sticky bad-line-length flag, cleared at frame start
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int   hRez         = 640,
  parameter int   vRez         = 480,
  parameter logic Y_FIRST      = 1'b1,
  parameter logic vsync_active = 1'b1
) (
  input  logic              clk24,
  input  logic              rst,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              frame_we,
  output logic [FB_AW-1:0]  frame_addr,
  output logic [GREY_W-1:0] frame_pixel,
  output logic              frame_done,
  output logic              line_err
);

  localparam logic [10:0]      LINE_BYTES = 11'(2 * hRez);
  localparam logic [9:0]       LINE_LIMIT = 10'(vRez);
  localparam logic [FB_AW-1:0] PIX_LIMIT  = FB_AW'(hRez * vRez);

  cap_state_t state, next_state;

  logic              d_vsync, d_href, href_q;
  logic [7:0]        d_data;
  logic              phase;
  logic [GREY_W-1:0] y_grey;
  logic              pix_pend;
  logic              done_q;
  logic [FB_AW-1:0]  address;
  logic [10:0]       byte_cnt;
  logic [9:0]        line_cnt;

  logic vsync_hit, href_rise, href_fall;
  logic phase_now, take_byte, pix_done, y_take, done_req;

  assign vsync_hit = (d_vsync == vsync_active);
  assign href_rise = d_href & ~href_q;
  assign href_fall = ~d_href & href_q;

  // A new line always starts on byte phase 0, so a stray odd byte left over
  // from the previous line is simply dropped.
  assign phase_now = href_rise ? 1'b0 : phase;
  assign take_byte = (state == ACTIVE) && !vsync_hit && d_href && (line_cnt < LINE_LIMIT);
  assign pix_done  = take_byte && phase_now;
  assign y_take    = take_byte && (phase_now != Y_FIRST);

  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      state <= WAIT_SYNC;
    end else begin
      state <= next_state;
    end
  end

  // Frame sequencing: wait for a full VSYNC pulse before trusting the bus,
  // so a frame already in flight at reset is never written.
  always_comb begin
    next_state = state;
    done_req   = 1'b0;
    case (state)
      WAIT_SYNC: if (vsync_hit) next_state = SYNC;
      SYNC:      if (!vsync_hit) next_state = ACTIVE;
      ACTIVE: begin
        if (vsync_hit) begin
          next_state = SYNC;
          done_req   = 1'b1;
        end
      end
      default:   next_state = WAIT_SYNC;
    endcase
  end

  // Datapath: input register, pixel assembly, write port and line checks.
  // frame_done is delayed one cycle behind the end-of-frame decision so that
  // a write still in flight at that moment always precedes the pulse.
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      d_vsync     <= 1'b0;
      d_href      <= 1'b0;
      d_data      <= '0;
      href_q      <= 1'b0;
      phase       <= 1'b0;
      y_grey      <= '0;
      pix_pend    <= 1'b0;
      done_q      <= 1'b0;
      address     <= '0;
      byte_cnt    <= '0;
      line_cnt    <= '0;
      frame_we    <= 1'b0;
      frame_addr  <= '0;
      frame_pixel <= '0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      d_vsync    <= cam_vsync;
      d_href     <= cam_href;
      d_data     <= cam_data;
      href_q     <= d_href;
      done_q     <= done_req;
      frame_done <= done_q;
      pix_pend   <= pix_done;

      if (y_take) y_grey <= grey_of(d_data);
      if (take_byte) phase <= ~phase_now;

      frame_we <= 1'b0;
      if (pix_pend && (address < PIX_LIMIT)) begin
        frame_we    <= 1'b1;
        frame_addr  <= address;
        frame_pixel <= y_grey;
        address     <= address + 1'b1;
      end

      if (href_rise) begin
        byte_cnt <= 11'd1;
      end else if (d_href && (byte_cnt != '1)) begin
        byte_cnt <= byte_cnt + 1'b1;
      end

      if (state == SYNC) begin
        address  <= '0;
        line_cnt <= '0;
        line_err <= 1'b0;
        phase    <= 1'b0;
      end else if ((state == ACTIVE) && href_fall) begin
        if (byte_cnt != LINE_BYTES) line_err <= 1'b1;
        if (line_cnt < LINE_LIMIT) line_cnt <= line_cnt + 1'b1;
      end
    end
  end

endmodule
